// File: rtl/gray_run_ctrl.sv
// Sequencer for the 3-bit Gray counter: runs one "N steps" command with pause/abort,
// counts completed laps and self-checks the final code and overflow flag.
module gray_run_ctrl #(
   parameter int STEP_W = 8,
   parameter int LAP_W  = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [STEP_W-1:0] Steps,
   input  logic              Pause,
   input  logic              Abort,
   output logic              GrayReset,
   output logic              GrayEn,
   input  logic [2:0]        GrayOut,
   input  logic              GrayOvf,
   output logic              Busy,
   output logic              Done,
   output logic [LAP_W-1:0]  Laps,
   output logic [2:0]        Final,
   output logic              Err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
   localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
   localparam logic [LAP_W-1:0]  LAP_ZERO  = {LAP_W{1'b0}};
   localparam logic [LAP_W-1:0]  LAP_ONE   = {{(LAP_W-1){1'b0}}, 1'b1};
   localparam logic [LAP_W-1:0]  LAP_MAX   = {LAP_W{1'b1}};

   state_t              state_r;
   logic [STEP_W-1:0]   rem_r;
   logic [STEP_W-1:0]   cmd_r;
   logic [LAP_W-1:0]    laps_r;
   logic [2:0]          final_r;
   logic                err_r;
   logic                gray_en_s;
   logic                exp_ovf_s;
   logic                check_err_s;

   function automatic logic [2:0] bin2gray(input logic [2:0] b);
      return b ^ {1'b0, b[2:1]};
   endfunction

   // Counter enable: only in RUN with steps remaining and neither pause nor abort.
   always_comb begin
      gray_en_s = 1'b0;
      if ((state_r == ST_RUN) && !Pause && !Abort && (rem_r != STEP_ZERO)) begin
         gray_en_s = 1'b1;
      end else begin
         gray_en_s = 1'b0;
      end
   end

   // End-of-run check: code must equal gray(N mod 8), overflow must match N >= 8.
   always_comb begin
      exp_ovf_s   = |cmd_r[STEP_W-1:3];
      check_err_s = (GrayOut != bin2gray(cmd_r[2:0])) || (GrayOvf != exp_ovf_s);
   end

   assign GrayReset = Reset || (state_r == ST_CLEAR);
   assign GrayEn    = gray_en_s;
   assign Busy      = (state_r != ST_IDLE);
   assign Done      = (state_r == ST_DONE);
   assign Laps      = laps_r;
   assign Final     = final_r;
   assign Err       = err_r;

   // Command sequencer with step, lap and result registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= ST_IDLE;
         rem_r   <= STEP_ZERO;
         cmd_r   <= STEP_ZERO;
         laps_r  <= LAP_ZERO;
         final_r <= 3'b000;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (Start) begin
                  rem_r   <= Steps;
                  cmd_r   <= Steps;
                  state_r <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               laps_r <= LAP_ZERO;
               if (Abort) begin
                  state_r <= ST_IDLE;
               end else if (cmd_r != STEP_ZERO) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_RUN: begin
               if (Abort) begin
                  state_r <= ST_IDLE;
               end else if (gray_en_s) begin
                  rem_r <= rem_r - STEP_ONE;
                  // 3'b100 is the last code of a lap; the next increment wraps.
                  if ((GrayOut == 3'b100) && (laps_r != LAP_MAX)) begin
                     laps_r <= laps_r + LAP_ONE;
                  end
                  if (rem_r == STEP_ONE) begin
                     state_r <= ST_DRAIN;
                  end
               end else if (rem_r == STEP_ZERO) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (Abort) begin
                  state_r <= ST_IDLE;
               end else begin
                  final_r <= GrayOut;
                  err_r   <= check_err_s;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Bench for gray_run_ctrl: behavioural Gray counter, command-level reference model
// checked every cycle, plus directed runs with hand-computed results.
module tb_gray_run_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic [7:0] Steps = 8'd0;
   logic       Pause = 1'b0;
   logic       Abort = 1'b0;
   logic       GrayReset, GrayEn, GrayOvf, Busy, Done, Err;
   logic [2:0] GrayOut, Final;
   logic [3:0] Laps;

   int errors = 0;
   int checks = 0;
   int edge_cnt = 0;

   // environment: behavioural 3-bit Gray counter with optional stuck-at-1 bits
   logic [2:0] bc_cnt = 3'd0;
   logic       bc_ovf = 1'b0;
   logic [2:0] stuck_mask = 3'b000;

   // reference model of the command, in terms of cycles and enables issued
   bit m_busy = 1'b0;
   int m_n = 0, m_cyc = 0, m_issued = 0, m_post = 0;
   int m_laps = 0, m_final = 0;
   bit m_err = 1'b0;
   logic ph_clear, ph_run, ph_tail;

   gray_run_ctrl #(.STEP_W(8), .LAP_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Steps(Steps),
      .Pause(Pause), .Abort(Abort), .GrayReset(GrayReset), .GrayEn(GrayEn),
      .GrayOut(GrayOut), .GrayOvf(GrayOvf), .Busy(Busy), .Done(Done),
      .Laps(Laps), .Final(Final), .Err(Err)
   );

   always #5 Clk = ~Clk;

   function automatic int gray_of(input int v);
      return v ^ (v >> 1);
   endfunction

   assign GrayOut = 3'(gray_of(int'(bc_cnt))) | stuck_mask;
   assign GrayOvf = bc_ovf;

   always @(posedge Clk) begin
      if (GrayReset) begin
         bc_cnt <= 3'd0;
         bc_ovf <= 1'b0;
      end else if (GrayEn) begin
         bc_cnt <= bc_cnt + 3'd1;
         if (bc_cnt == 3'd7) bc_ovf <= 1'b1;
      end
   end

   assign ph_clear = m_busy && (m_cyc == 1);
   assign ph_run   = m_busy && (m_cyc >= 2) && (m_issued < m_n);
   assign ph_tail  = m_busy && (m_cyc >= 2) && (m_issued == m_n);

   always @(posedge Clk) begin
      edge_cnt <= edge_cnt + 1;
      if (Reset) begin
         m_busy <= 1'b0; m_laps <= 0; m_final <= 0; m_err <= 1'b0;
      end else if (!m_busy) begin
         if (Start) begin
            m_busy <= 1'b1; m_n <= int'(Steps); m_cyc <= 1; m_issued <= 0; m_post <= 0;
         end
      end else if (Abort) begin
         m_busy <= 1'b0;
         if (ph_clear) m_laps <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (ph_clear) m_laps <= 0;
         if (ph_run && !Pause) begin
            m_issued <= m_issued + 1;
            m_laps   <= (((m_issued + 1) / 8) > 15) ? 15 : ((m_issued + 1) / 8);
         end
         if (ph_tail) begin
            m_post <= m_post + 1;
            if (m_post == 0) begin
               m_final <= int'(GrayOut);
               m_err   <= (int'(GrayOut) != gray_of(m_n % 8)) || (GrayOvf != (m_n >= 8));
            end else begin
               m_busy <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge Clk) begin
      chk("GrayReset", 32'(GrayReset), 32'(Reset || ph_clear));
      chk("GrayEn",    32'(GrayEn),    32'(ph_run && !Pause && !Abort));
      chk("Busy",      32'(Busy),      32'(m_busy));
      chk("Done",      32'(Done),      32'(ph_tail && (m_post == 1)));
      chk("Laps",      32'(Laps),      32'(m_laps));
      chk("Final",     32'(Final),     32'(m_final));
      chk("Err",       32'(Err),       32'(m_err));
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_cmd(input int n, input int pause_at, input int pause_len,
                          input int abort_at, input bit glitch,
                          output int lat, output int ens, output bit got_done,
                          output bit ovf_done);
      int t0, pcnt;
      bit aborted, fin;
      lat = -1; ens = 0; got_done = 1'b0; ovf_done = 1'b0;
      pcnt = 0; aborted = 1'b0; fin = 1'b0;
      Start = 1'b1; Steps = 8'(n);
      tick();
      t0 = edge_cnt;
      Start = 1'b0;
      for (int i = 0; i < 600 && !fin; i++) begin
         Pause = (pause_len > 0 && ens == pause_at && pcnt < pause_len) ? 1'b1 : 1'b0;
         if (Pause) pcnt++;
         Abort = (abort_at >= 0 && ens == abort_at && !aborted) ? 1'b1 : 1'b0;
         if (Abort) aborted = 1'b1;
         if (glitch) begin
            Start = (i == 1) ? 1'b1 : 1'b0;
            Steps = 8'd7;
         end
         @(negedge Clk);
         if (GrayEn) ens++;
         if (Done) begin
            got_done = 1'b1;
            lat = edge_cnt - t0 + 1;
            ovf_done = GrayOvf;
         end
         if (!Busy) fin = 1'b1;
         else tick();
      end
      if (!fin) chk("cmd_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int lat, ens;
      bit gd, ovf;

      repeat (2) tick();
      @(negedge Clk);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_greset", 32'(GrayReset), 32'd1);
      chk("rst_laps", 32'(Laps), 32'd0);
      chk("rst_final_err", {Final, Err}, 32'd0);
      tick();
      Reset = 1'b0;
      tick();

      run_cmd(5, 0, 0, -1, 1'b0, lat, ens, gd, ovf);
      chk("n5_ens", ens, 5);
      chk("n5_lat", lat, 8);
      chk("n5_final", 32'(Final), 32'd7);
      chk("n5_laps", 32'(Laps), 32'd0);
      chk("n5_err", 32'(Err), 32'd0);
      tick();

      run_cmd(8, 0, 0, -1, 1'b0, lat, ens, gd, ovf);
      chk("n8_final", 32'(Final), 32'd0);
      chk("n8_laps", 32'(Laps), 32'd1);
      chk("n8_ovf", 32'(ovf), 32'd1);
      chk("n8_err", 32'(Err), 32'd0);
      chk("n8_lat", lat, 11);
      tick();

      run_cmd(20, 0, 0, -1, 1'b0, lat, ens, gd, ovf);
      chk("n20_final", 32'(Final), 32'd6);
      chk("n20_laps", 32'(Laps), 32'd2);
      chk("n20_err", 32'(Err), 32'd0);
      chk("n20_lat", lat, 23);
      tick();

      run_cmd(0, 0, 0, -1, 1'b1, lat, ens, gd, ovf);
      chk("n0_ens", ens, 0);
      chk("n0_lat", lat, 3);
      chk("n0_final", 32'(Final), 32'd0);
      chk("n0_err_busy_start", 32'(Err), 32'd0);
      tick();

      run_cmd(6, 3, 3, -1, 1'b0, lat, ens, gd, ovf);
      chk("pause_ens", ens, 6);
      chk("pause_lat", lat, 12);
      chk("pause_final", 32'(Final), 32'd5);
      tick();

      run_cmd(10, 0, 0, 4, 1'b0, lat, ens, gd, ovf);
      chk("abort_done", 32'(gd), 32'd0);
      chk("abort_ens", ens, 4);
      chk("abort_final", 32'(Final), 32'd5);
      chk("abort_err", 32'(Err), 32'd0);
      chk("abort_laps", 32'(Laps), 32'd0);
      tick();

      run_cmd(255, 0, 0, -1, 1'b0, lat, ens, gd, ovf);
      chk("n255_laps_sat", 32'(Laps), 32'd15);
      chk("n255_final", 32'(Final), 32'd4);
      chk("n255_err", 32'(Err), 32'd0);
      chk("n255_lat", lat, 258);
      tick();

      stuck_mask = 3'b001;
      run_cmd(3, 0, 0, -1, 1'b0, lat, ens, gd, ovf);
      chk("fault_final", 32'(Final), 32'd3);
      chk("fault_err", 32'(Err), 32'd1);
      stuck_mask = 3'b000;
      tick();

      Start = 1'b1; Steps = 8'd20;
      tick();
      Start = 1'b0;
      repeat (13) tick();
      @(negedge Clk);
      chk("midrun_laps", 32'(Laps), 32'd1);
      tick();
      Reset = 1'b1;
      @(negedge Clk);
      chk("midrun_greset", 32'(GrayReset), 32'd1);
      tick();
      Reset = 1'b0;
      @(negedge Clk);
      chk("midrun_busy", 32'(Busy), 32'd0);
      chk("midrun_done", 32'(Done), 32'd0);
      chk("midrun_laps_rst", 32'(Laps), 32'd0);
      chk("midrun_final_err", {Final, Err}, 32'd0);
      tick();

      run_cmd(1, 0, 0, -1, 1'b0, lat, ens, gd, ovf);
      chk("n1_final", 32'(Final), 32'd1);
      chk("n1_lat", lat, 4);
      chk("n1_err", 32'(Err), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
